// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths, reset level and constants for the operand-fetch stage
package operand_fetch_stage_pkg;
  localparam logic RST_ENABLE = 1'b1;
  localparam int DATA_BUS_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W = 8;
  localparam logic [DATA_BUS_W-1:0] ZERO_WORD = '0;
  localparam logic [ALU_OP_W-1:0] NOP_OP = '0;
endpackage

// File: rtl/operand_fetch_stage_fwd_mux.sv
// operand_fetch_stage_fwd_mux: per-source operand priority mux (zero, EX forward, MEM forward, register file)
module operand_fetch_stage_fwd_mux
  import operand_fetch_stage_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);
  always_comb
    data = (!re || addr == '0)          ? '0        :
           (ex_wreg && ex_wd == addr)   ? ex_wdata  :
           (mem_wreg && mem_wd == addr) ? mem_wdata : rf_data;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register read, EX/MEM forwarding, load-use detection and the ID/EX register
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int OP_W = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rs_re,
  input  logic              id_rt_re,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic [ADDR_W-1:0] id_wd,
  input  logic              id_wreg,
  input  logic              id_is_load,
  output logic [ADDR_W-1:0] reg1_addr,
  input  logic [DATA_W-1:0] reg1_data,
  output logic [ADDR_W-1:0] reg2_addr,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic              ex_fwd_wreg,
  input  logic [ADDR_W-1:0] ex_fwd_wd,
  input  logic [DATA_W-1:0] ex_fwd_wdata,
  input  logic              mem_fwd_wreg,
  input  logic [ADDR_W-1:0] mem_fwd_wd,
  input  logic [DATA_W-1:0] mem_fwd_wdata,
  input  logic              stall,
  input  logic              flush,
  output logic              stall_req,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_aluop,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [ADDR_W-1:0] ex_wd,
  output logic              ex_wreg,
  output logic              ex_is_load
);
  logic [DATA_W-1:0] op1, op2;
  logic bubble;
  assign reg1_addr = id_rs_re ? id_rs_addr : '0;
  assign reg2_addr = id_rt_re ? id_rt_addr : '0;
  operand_fetch_stage_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
    .re(id_rs_re), .addr(id_rs_addr),
    .ex_wreg(ex_fwd_wreg), .ex_wd(ex_fwd_wd), .ex_wdata(ex_fwd_wdata),
    .mem_wreg(mem_fwd_wreg), .mem_wd(mem_fwd_wd), .mem_wdata(mem_fwd_wdata),
    .rf_data(reg1_data), .data(op1)
  );
  operand_fetch_stage_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
    .re(id_rt_re), .addr(id_rt_addr),
    .ex_wreg(ex_fwd_wreg), .ex_wd(ex_fwd_wd), .ex_wdata(ex_fwd_wdata),
    .mem_wreg(mem_fwd_wreg), .mem_wd(mem_fwd_wd), .mem_wdata(mem_fwd_wdata),
    .rf_data(reg2_data), .data(op2)
  );
  // the load sitting in EX has no data yet, so a dependent consumer must wait one cycle
  assign stall_req = id_valid && ex_is_load && ex_wreg && ex_wd != '0 &&
                     ((id_rs_re && id_rs_addr == ex_wd) || (id_rt_re && id_rt_addr == ex_wd));
  assign bubble = flush || (!stall && stall_req);
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || bubble) begin
      ex_valid   <= 1'b0;
      ex_aluop   <= NOP_OP[OP_W-1:0];
      ex_reg1    <= '0;
      ex_reg2    <= '0;
      ex_wd      <= '0;
      ex_wreg    <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      ex_aluop   <= id_aluop;
      ex_reg1    <= op1;
      ex_reg2    <= op2;
      ex_wd      <= id_wd;
      ex_wreg    <= id_wreg && id_valid;
      ex_is_load <= id_is_load && id_valid;
    end
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Operand-fetch half of the MIPS ID stage and the ID/EX pipeline register, sitting directly upstream of the EX stage.
- Drives the two register-file read addresses and consumes the combinational read data.
- Resolves EX and MEM forwarding and detects load-use hazards.
- Registers the resolved operands and the decoded control into the ID/EX register, with stall, flush and bubble insertion.
- Write-back forwarding is not handled here; the register file already bypasses same-cycle writes.

Parameters:
- DATA_W, 32, width of register data and operands
- ADDR_W, 5, register address width
- OP_W, 8, width of the ALU op code carried to EX

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decoded instruction present this cycle
- id_rs_addr  in  ADDR_W  source register 1
- id_rt_addr  in  ADDR_W  source register 2
- id_rs_re  in  1  source 1 is read
- id_rt_re  in  1  source 2 is read
- id_aluop  in  OP_W  decoded ALU op
- id_wd  in  ADDR_W  destination register
- id_wreg  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- reg1_addr  out  ADDR_W  register-file read port 1 address
- reg1_data  in  DATA_W  register-file read port 1 data (combinational)
- reg2_addr  out  ADDR_W  register-file read port 2 address
- reg2_data  in  DATA_W  register-file read port 2 data (combinational)
- ex_fwd_wreg  in  1  EX stage result will be written
- ex_fwd_wd  in  ADDR_W  EX stage destination register
- ex_fwd_wdata  in  DATA_W  EX stage result
- mem_fwd_wreg  in  1  MEM stage result will be written
- mem_fwd_wd  in  ADDR_W  MEM stage destination register
- mem_fwd_wdata  in  DATA_W  MEM stage result
- stall  in  1  global stall from the control unit; hold the ID/EX register
- flush  in  1  pipeline flush; the ID/EX register becomes a bubble
- stall_req  out  1  load-use hazard; control must hold IF/ID for one cycle
- ex_valid  out  1  registered: instruction valid in EX
- ex_aluop  out  OP_W  registered ALU op
- ex_reg1  out  DATA_W  registered operand 1
- ex_reg2  out  DATA_W  registered operand 2
- ex_wd  out  ADDR_W  registered destination register
- ex_wreg  out  1  registered write enable
- ex_is_load  out  1  registered load flag

Behaviour:
- Read addresses:
  - reg1_addr = id_rs_addr when id_rs_re, else 0.
  - reg2_addr = id_rt_addr when id_rt_re, else 0.
  - Both are combinational.
- Operand resolution, per source, first match wins:
  1. Read disabled or address 0: value 0.
  2. ex_fwd_wreg and ex_fwd_wd equals the source address: ex_fwd_wdata.
  3. mem_fwd_wreg and mem_fwd_wd equals the source address: mem_fwd_wdata.
  4. Otherwise: the register-file read data.
- Load-use detection:
  - stall_req = id_valid AND registered ex_is_load AND registered ex_wreg AND ex_wd != 0 AND ex_wd equals an enabled source address.
  - stall_req is combinational and is not affected by stall or flush.
  - The registered ex_* outputs are the instruction currently in EX, so no external load flag is needed.
- ID/EX register update on the rising clk edge, priority high to low:
  1. rst: all outputs 0.
  2. flush: ex_valid, ex_wreg and ex_is_load go to 0; the data fields go to 0.
  3. stall: all ex_* outputs hold their values.
  4. stall_req: bubble, same values as flush.
  5. Otherwise: load the resolved operands and the id_* fields.
     - ex_valid = id_valid.
     - ex_wreg and ex_is_load are gated by id_valid.
- Reset value of every registered output is 0. stall_req is 0 during reset because ex_is_load is 0.
- Latency: one cycle from the ID inputs to the ex_* outputs.
- A bubble never asserts ex_wreg, so it never triggers forwarding or load-use.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stall clears the register; the held instruction is discarded.
- A back-to-back load followed by a dependent instruction causes exactly one bubble. In the next cycle ex_is_load is 0 and the MEM forward supplies the data.

Decomposition:
- Shared defines header holds rst_enable, the zero word, the bus widths, the register-address width, the ALU op width and the NOP op code.
- One natural sub-module: fwd_mux, the per-source forwarding priority mux, instantiated twice.

Test Plan:
1. Reset: rst=1 for two cycles with random inputs -> all ex_* = 0 and stall_req = 0.
2. No hazard: id_rs=3, id_rt=4, reg1_data=0x11, reg2_data=0x22, no forwards -> next cycle ex_reg1=0x11, ex_reg2=0x22, ex_valid=1.
3. Forward priority: rs=5; ex_fwd writes 5 with 0xAAAA; mem_fwd writes 5 with 0xBBBB; regfile returns 0xCCCC -> ex_reg1=0xAAAA. With ex_fwd_wreg=0 -> ex_reg1=0xBBBB.
4. Register 0: rs=0 with ex_fwd writing reg 0 = 0xFFFF -> ex_reg1=0.
5. Load-use: issue a load to r7, then a dependent op with rs=7 -> stall_req=1 for one cycle and a bubble (ex_valid=0). Next cycle, with the MEM forward supplying 0x1234 -> ex_reg1=0x1234.
6. Control: stall held three cycles -> ex_* unchanged. flush and stall together -> ex_valid=0. rst during stall -> all ex_* = 0.
